// File: rtl/camera_qsys_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-source edge/level pending, mask, W1C, SWSET, priority vector.
// Optional macro CAMERA_QSYS_IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module camera_qsys_irq_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    output logic             cpu_irq
);

    // All registers are kept 16 bits wide; bits at or above N_IRQ are forced to 0.
    localparam logic [15:0] VALID = 16'((32'd1 << N_IRQ) - 32'd1);

    logic [15:0] irq_w;
    logic [15:0] s;
    logic [15:0] s_d_q, s_d_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] enable_q, enable_d;
    logic [15:0] mode_q, mode_d;
    logic [15:0] readdata_q, readdata_d;
    logic        cpu_irq_q, cpu_irq_d;

    logic        wr_en;
    logic [15:0] wdata;
    logic [15:0] w1c;
    logic [15:0] swset;
    logic [15:0] rise;
    logic [15:0] active;
    logic [3:0]  vec_idx;

    assign irq_w = 16'(irq_in);

`ifdef CAMERA_QSYS_IRQ_CTRL_SYNC_EN
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_w & VALID;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = irq_w & VALID;
`endif

    always_comb begin
        wr_en    = chipselect && !write_n;
        wdata    = writedata & VALID;
        w1c      = (wr_en && address == 3'd0) ? wdata : 16'h0000;
        swset    = (wr_en && address == 3'd5) ? wdata : 16'h0000;
        rise     = s & ~s_d_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_en && address == 3'd1) enable_d = wdata;
        if (wr_en && address == 3'd2) mode_d = wdata;
        // Level bits follow s; edge bits: set (edge or swset) wins over W1C, else hold.
        pending_d = ((~mode_q & s) | (mode_q & (rise | swset | (pending_q & ~w1c)))) & VALID;
        s_d_d     = s;
        active    = pending_q & enable_q;
        cpu_irq_d = |active;
    end

    always_comb begin
        vec_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) vec_idx = 4'(i);
        end
        case (address)
            3'd0:    readdata_d = pending_q;
            3'd1:    readdata_d = enable_q;
            3'd2:    readdata_d = mode_q;
            3'd3:    readdata_d = active;
            3'd4:    readdata_d = {|active, 11'b0, vec_idx};
            default: readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_d_q      <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            readdata_q <= '0;
            cpu_irq_q  <= 1'b0;
        end else begin
            s_d_q      <= s_d_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            cpu_irq_q  <= cpu_irq_d;
        end
    end

    assign readdata = readdata_q;
    assign cpu_irq  = cpu_irq_q;

endmodule
